// File: rtl/vsfx_pkg.sv
// Shared definitions for the vsfx writeback stage.
//   VR_W        : vector register width in bits
//   AW_DEFAULT  : default vector register address width
//   wb_entry_t  : one queued writeback record {addr, data}
package vsfx_pkg;

  localparam int VR_W       = 128;
  localparam int AW_DEFAULT = 5;

  typedef struct packed {
    logic [AW_DEFAULT-1:0] addr;
    logic [VR_W-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/vsfx_wb_fifo.sv
// Synchronous FIFO used by the vector writeback stages.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : enqueue request and data (accepted when not full, or
//                when a pop happens in the same cycle)
//   pop        : dequeue request (ignored when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries (0..DEPTH)
//   dout       : head entry, combinational read of registered storage
module vsfx_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 133
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign dout  = mem[rd_ptr];

  // A pop in the same cycle frees the head slot, so a push into a full
  // FIFO is still accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH for free.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by
  // count/pointers, and leaving the array reset-free keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vsfx_wb.sv
// Writeback stage downstream of the vector simple fixed-point unit.
// Queues vsfx results, drains them to the VR file write port via req/ack,
// and maintains sticky VSCR[SAT], architected CR6 and a sticky overflow.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_vrt_en, in_vrt,
//   in_sat, in_cr6, in_rc,
//   in_addr                  : vsfx result and side information
//   stall                    : queue full, issue must hold
//   wr_req, wr_addr, wr_data : register-file write request (head entry)
//   wr_ack                   : arbiter grant, retires the head entry
//   vscr_wr_en, vscr_wr_sat  : mtvscr write of SAT
//   vscr_sat, cr6            : architected state
//   ovf                      : sticky, a result was dropped while full
module vsfx_wb
  import vsfx_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vrt_en,
  input  logic [VR_W-1:0] in_vrt,
  input  logic            in_sat,
  input  logic [3:0]      in_cr6,
  input  logic            in_rc,
  input  logic [AW-1:0]   in_addr,
  output logic            stall,
  output logic            wr_req,
  output logic [AW-1:0]   wr_addr,
  output logic [VR_W-1:0] wr_data,
  input  logic            wr_ack,
  input  logic            vscr_wr_en,
  input  logic            vscr_wr_sat,
  output logic            vscr_sat,
  output logic [3:0]      cr6,
  output logic            ovf
);

  localparam int EW = AW + VR_W;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [EW-1:0] head;
  logic          pop;

  assign pop = wr_req & wr_ack;

  vsfx_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_vrt_en),
    .din   ({in_addr, in_vrt}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (head)
  );

  assign wr_req = ~fifo_empty;
  assign stall  = (fifo_count == FULL_CNT);

  // Storage is not reset, so the head is masked while empty to present
  // clean zeros on the write port.
  assign wr_addr = wr_req ? head[EW-1:VR_W] : '0;
  assign wr_data = wr_req ? head[VR_W-1:0]  : '0;

  // SAT is folded in at capture time; a saturating result beats an
  // mtvscr clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vscr_sat <= 1'b0;
      cr6      <= 4'b0000;
      ovf      <= 1'b0;
    end else begin
      vscr_sat <= (vscr_wr_en ? vscr_wr_sat : vscr_sat) | (in_vrt_en & in_sat);
      if (in_vrt_en && in_rc) cr6 <= in_cr6;
      if (in_vrt_en && fifo_full && !pop) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vsfx_wb.sv
module tb_vsfx_wb;
  import vsfx_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vrt_en;
  logic [VR_W-1:0] in_vrt;
  logic            in_sat;
  logic [3:0]      in_cr6;
  logic            in_rc;
  logic [4:0]      in_addr;
  logic            stall;
  logic            wr_req;
  logic [4:0]      wr_addr;
  logic [VR_W-1:0] wr_data;
  logic            wr_ack;
  logic            vscr_wr_en;
  logic            vscr_wr_sat;
  logic            vscr_sat;
  logic [3:0]      cr6;
  logic            ovf;

  int errors = 0;
  int checks = 0;
  wb_entry_t sb[$];

  vsfx_wb #(.DEPTH(4), .AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vrt_en   (in_vrt_en),
    .in_vrt      (in_vrt),
    .in_sat      (in_sat),
    .in_cr6      (in_cr6),
    .in_rc       (in_rc),
    .in_addr     (in_addr),
    .stall       (stall),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .vscr_wr_en  (vscr_wr_en),
    .vscr_wr_sat (vscr_wr_sat),
    .vscr_sat    (vscr_sat),
    .cr6         (cr6),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every granted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && wr_req && wr_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_write_addr", 128'(wr_addr), 128'h1ff);
      end else begin
        wb_entry_t e;
        e = sb.pop_front();
        check("wr_addr", 128'(wr_addr), 128'(e.addr));
        check("wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle result; queued on the scoreboard only when expected to land.
  task automatic push(input logic [4:0] addr, input logic [127:0] data,
                      input logic sat, input logic rc, input logic [3:0] c6,
                      input bit expect_write);
    wb_entry_t e;
    in_vrt_en = 1'b1;
    in_addr   = addr;
    in_vrt    = data;
    in_sat    = sat;
    in_rc     = rc;
    in_cr6    = c6;
    if (expect_write) begin
      e.addr = addr;
      e.data = data;
      sb.push_back(e);
    end
    step();
    in_vrt_en = 1'b0;
    in_sat    = 1'b0;
    in_rc     = 1'b0;
  endtask

  task automatic drain();
    int n;
    wr_ack = 1'b1;
    n = 0;
    while (wr_req && n < 20) begin
      step();
      n++;
    end
    check("drain_done", 128'(wr_req), 128'(0));
    check("sb_left", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b0; in_vrt_en = 1'b0; in_vrt = '0; in_sat = 1'b0; in_cr6 = '0;
    in_rc = 1'b0; in_addr = '0; wr_ack = 1'b0; vscr_wr_en = 1'b0; vscr_wr_sat = 1'b0;

    // Reset state
    do_reset();
    check("rst_wr_req",   128'(wr_req),   128'(0));
    check("rst_stall",    128'(stall),    128'(0));
    check("rst_wr_addr",  128'(wr_addr),  128'(0));
    check("rst_wr_data",  wr_data,        128'(0));
    check("rst_vscr_sat", 128'(vscr_sat), 128'(0));
    check("rst_cr6",      128'(cr6),      128'(0));
    check("rst_ovf",      128'(ovf),      128'(0));

    // Single result, ack tied high: one-cycle write request
    wr_ack = 1'b1;
    push(5'd3, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0, 1'b0, 4'h0, 1'b1);
    check("t1_req",     128'(wr_req),   128'(1));
    check("t1_addr",    128'(wr_addr),  128'(3));
    check("t1_data",    wr_data,        128'h0123456789ABCDEF0123456789ABCDEF);
    step();
    check("t1_req_off", 128'(wr_req),   128'(0));
    check("t1_sat",     128'(vscr_sat), 128'(0));

    // Fill and overflow
    wr_ack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("t2_stall_pre", 128'(stall), 128'(0));
      push(5'(i), rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    end
    check("t2_stall_full", 128'(stall), 128'(1));
    check("t2_ovf_pre",    128'(ovf),   128'(0));
    push(5'd9, rnd128(), 1'b0, 1'b0, 4'h0, 1'b0);
    check("t2_ovf",        128'(ovf),   128'(1));
    check("t2_stall_hold", 128'(stall), 128'(1));
    check("t2_head_hold",  128'(wr_addr), 128'(1));
    drain();
    check("t2_ovf_sticky", 128'(ovf),   128'(1));

    // Full with simultaneous push and pop
    do_reset();
    wr_ack = 1'b0;
    for (int i = 11; i <= 14; i++) push(5'(i), rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    check("t3_full", 128'(stall), 128'(1));
    wr_ack = 1'b1;
    push(5'd7, rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    check("t3_count_stays_4", 128'(stall), 128'(1));
    check("t3_ovf",           128'(ovf),   128'(0));
    check("t3_head",          128'(wr_addr), 128'(12));
    drain();

    // Sticky SAT versus mtvscr
    push(5'd20, rnd128(), 1'b1, 1'b0, 4'h0, 1'b1);
    check("sat_set",  128'(vscr_sat), 128'(1));
    push(5'd21, rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    check("sat_hold", 128'(vscr_sat), 128'(1));
    vscr_wr_en = 1'b1; vscr_wr_sat = 1'b0;
    step();
    vscr_wr_en = 1'b0;
    check("sat_clear", 128'(vscr_sat), 128'(0));
    vscr_wr_en = 1'b1; vscr_wr_sat = 1'b0;
    push(5'd22, rnd128(), 1'b1, 1'b0, 4'h0, 1'b1);
    vscr_wr_en = 1'b0;
    check("sat_wins_over_clear", 128'(vscr_sat), 128'(1));

    // CR6 gated by record form
    push(5'd23, rnd128(), 1'b0, 1'b1, 4'b1000, 1'b1);
    check("cr6_set", 128'(cr6), 128'(4'b1000));
    push(5'd24, rnd128(), 1'b0, 1'b0, 4'b0010, 1'b1);
    check("cr6_gated", 128'(cr6), 128'(4'b1000));
    step();
    check("cr6_hold", 128'(cr6), 128'(4'b1000));
    drain();

    // Reset mid-drain
    wr_ack = 1'b0;
    push(5'd25, rnd128(), 1'b1, 1'b1, 4'b0101, 1'b1);
    push(5'd26, rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    push(5'd27, rnd128(), 1'b0, 1'b0, 4'h0, 1'b1);
    check("t6_req_pre", 128'(wr_req), 128'(1));
    do_reset();
    wr_ack = 1'b1;
    check("t6_req",   128'(wr_req),   128'(0));
    check("t6_stall", 128'(stall),    128'(0));
    check("t6_sat",   128'(vscr_sat), 128'(0));
    check("t6_cr6",   128'(cr6),      128'(0));
    check("t6_ovf",   128'(ovf),      128'(0));
    step();
    check("t6_req_after", 128'(wr_req), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
